// File: rtl/core_hzrd_ctrl.sv
// -----------------------------------------------------------------------------
// core_hzrd_ctrl
//
// Pipeline sequencer and hazard controller for the five-stage Selen core
// (IF, DEC, EXE, MEM, WB).
//
// It drives the load enables of the IF/DEC, DEC/EXE and EXE/MEM pipeline
// registers, the bubble insert into DEC/EXE, NOP conversion of the decode
// word and the PC-redirect select. It also produces the registered EXE-stage
// operand-forwarding selects.
//
// A small shadow pipeline of {valid, we, rd, cmd} for EXE, MEM and WB is kept
// alongside the datapath. It is fed from the decode hazard bus. The shadow
// lets hazards be detected without looking into the datapath registers.
//
// Ports
//   clk              system clock
//   rst              synchronous, active-high reset
//   dec_hazard_bus   {rs1[14:10], rs2[9:5], rd[4:0]} of the DEC instruction
//   dec_hazard_cmd   DEC instruction type: 00 other, 01 branch, 10 jump,
//                    11 load
//   dec_we           DEC instruction writes the register file
//   il1_ack          I-cache returned a valid word this cycle
//   dl1_req          MEM stage holds a valid load/store request
//   dl1_ack          D-cache completed the MEM request
//   exe_brnch_taken  EXE resolved a taken branch or jump
//   if_enb .. mem_enb  stage register load enables
//   dec_kill         load a bubble into DEC/EXE
//   dec_nop_gen      decode treats its instruction as a NOP
//   pc_sel           00 PC+4, 01 EXE branch/jump target
//   fwd_src1_sel     registered EXE operand-1 source:
//                    00 regfile, 01 MEM ALU result, 10 WB data
//   fwd_src2_sel     same encoding for operand 2
//   stall_out        any stall or hold active
// -----------------------------------------------------------------------------
module core_hzrd_ctrl #(
  parameter int unsigned RST_HOLD_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [14:0] dec_hazard_bus,
  input  logic [1:0]  dec_hazard_cmd,
  input  logic        dec_we,
  input  logic        il1_ack,
  input  logic        dl1_req,
  input  logic        dl1_ack,
  input  logic        exe_brnch_taken,
  output logic        if_enb,
  output logic        dec_enb,
  output logic        exe_enb,
  output logic        mem_enb,
  output logic        dec_kill,
  output logic        dec_nop_gen,
  output logic [1:0]  pc_sel,
  output logic [1:0]  fwd_src1_sel,
  output logic [1:0]  fwd_src2_sel,
  output logic        stall_out
);

  // ---------------------------------------------------------------------------
  // Encodings and types
  // ---------------------------------------------------------------------------
  localparam logic [1:0] CMD_OTHER  = 2'b00;
  localparam logic [1:0] CMD_BRANCH = 2'b01;
  localparam logic [1:0] CMD_JUMP   = 2'b10;
  localparam logic [1:0] CMD_LOAD   = 2'b11;

  localparam logic [1:0] PC_SEL_SEQ    = 2'b00;
  localparam logic [1:0] PC_SEL_TARGET = 2'b01;

  localparam logic [1:0] FWD_REGFILE = 2'b00;
  localparam logic [1:0] FWD_MEM_ALU = 2'b01;
  localparam logic [1:0] FWD_WB      = 2'b10;

  localparam int unsigned CNT_W = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_HOLD,   // post-reset hold, every stage killed
    ST_RUN,    // normal operation
    ST_FLUSH,  // cycle after a redirect, wrong-path DEC word squashed
    ST_DWAIT   // frozen behind an outstanding D-cache request
  } state_t;

  typedef struct packed {
    logic       valid;
    logic       we;
    logic [4:0] rd;
    logic [1:0] cmd;
  } shadow_t;

  // ---------------------------------------------------------------------------
  // Decode hazard bus fields
  // ---------------------------------------------------------------------------
  logic [4:0] dec_rs1;
  logic [4:0] dec_rs2;
  logic [4:0] dec_rd;

  assign dec_rs1 = dec_hazard_bus[14:10];
  assign dec_rs2 = dec_hazard_bus[9:5];
  assign dec_rd  = dec_hazard_bus[4:0];

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt_q;
  shadow_t          exe_sh;
  shadow_t          mem_sh;
  shadow_t          wb_sh;
  logic [1:0]       fwd1_d;
  logic [1:0]       fwd2_d;

  // ---------------------------------------------------------------------------
  // Hazard conditions
  // ---------------------------------------------------------------------------
  logic dwait_cond;
  logic redirect;
  logic load_use;
  logic icache_miss;
  logic hold_done;
  logic dec_advance;

  assign dwait_cond  = dl1_req & ~dl1_ack;

  // Only a real branch or jump in EXE may redirect. A bubble or ordinary
  // instruction there makes a stray exe_brnch_taken harmless.
  assign redirect    = exe_brnch_taken & exe_sh.valid &
                       ((exe_sh.cmd == CMD_BRANCH) | (exe_sh.cmd == CMD_JUMP));

  assign load_use    = exe_sh.valid & (exe_sh.cmd == CMD_LOAD) & exe_sh.we &
                       (exe_sh.rd != 5'd0) &
                       ((exe_sh.rd == dec_rs1) | (exe_sh.rd == dec_rs2));

  assign icache_miss = ~il1_ack;
  assign hold_done   = (hold_cnt_q == HOLD_LAST);
  assign dec_advance = dec_enb & ~dec_kill;

  // ---------------------------------------------------------------------------
  // Forwarding source pick for one operand.
  //
  // The producer now in EXE will sit in MEM when the consumer reaches EXE.
  // That producer therefore forwards from the MEM ALU result (01).
  // The producer now in MEM will be in WB, so it forwards WB data (10).
  // A load in EXE never forwards from MEM. Its data does not exist yet, and
  // the load-use stall separates the two instructions first.
  // ---------------------------------------------------------------------------
  function automatic logic [1:0] fwd_pick(input logic [4:0] rs,
                                          input shadow_t    e,
                                          input shadow_t    m);
    logic [1:0] sel;
    sel = FWD_REGFILE;
    if (e.valid && e.we && (e.rd != 5'd0) && (e.rd == rs) && (e.cmd != CMD_LOAD))
      sel = FWD_MEM_ALU;
    else if (m.valid && m.we && (m.rd != 5'd0) && (m.rd == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  assign fwd1_d = fwd_pick(dec_rs1, exe_sh, mem_sh);
  assign fwd2_d = fwd_pick(dec_rs2, exe_sh, mem_sh);

  // ---------------------------------------------------------------------------
  // Stage control and next state (combinational)
  // ---------------------------------------------------------------------------
  // NOTE: every output of this block gets a default before the case. No path
  // can then leave a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    if_enb      = 1'b1;
    dec_enb     = 1'b1;
    exe_enb     = 1'b1;
    mem_enb     = 1'b1;
    dec_kill    = 1'b0;
    dec_nop_gen = 1'b0;
    pc_sel      = PC_SEL_SEQ;
    stall_out   = 1'b0;
    state_d     = state_q;

    unique case (state_q)
      ST_HOLD: begin
        if_enb      = 1'b0;
        dec_enb     = 1'b0;
        exe_enb     = 1'b0;
        mem_enb     = 1'b0;
        dec_kill    = 1'b1;
        dec_nop_gen = 1'b1;
        stall_out   = 1'b1;
        if (hold_done)
          state_d = ST_RUN;
      end

      ST_FLUSH: begin
        // The word in IF/DEC was fetched down the wrong path.
        dec_nop_gen = 1'b1;
        if (dwait_cond) begin
          if_enb    = 1'b0;
          dec_enb   = 1'b0;
          exe_enb   = 1'b0;
          mem_enb   = 1'b0;
          stall_out = 1'b1;
          state_d   = ST_DWAIT;
        end else begin
          state_d   = ST_RUN;
        end
      end

      // DWAIT re-runs the RUN priority list on every cycle. The cycle that
      // sees dl1_ack therefore releases and applies any pending event at once.
      // A redirect held during the wait is one such event.
      ST_RUN, ST_DWAIT: begin
        if (dwait_cond) begin
          if_enb    = 1'b0;
          dec_enb   = 1'b0;
          exe_enb   = 1'b0;
          mem_enb   = 1'b0;
          stall_out = 1'b1;
          state_d   = ST_DWAIT;
        end else if (redirect) begin
          pc_sel    = PC_SEL_TARGET;
          dec_kill  = 1'b1;
          state_d   = ST_FLUSH;
        end else if (load_use) begin
          // Hold the consumer in DEC and send one bubble down. Next cycle
          // the load has moved to MEM, so the match no longer fires.
          if_enb    = 1'b0;
          dec_kill  = 1'b1;
          stall_out = 1'b1;
          state_d   = ST_RUN;
        end else if (icache_miss) begin
          if_enb      = 1'b0;
          dec_nop_gen = 1'b1;
          stall_out   = 1'b1;
          state_d     = ST_RUN;
        end else begin
          state_d = ST_RUN;
        end
      end

      default: begin
        state_d = ST_HOLD;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Sequential state: FSM, hold counter, shadows, forwarding selects
  // ---------------------------------------------------------------------------
  // NOTE: all state here uses non-blocking assignments. Every register then
  // samples values from before the edge, so the shadow shift cannot race.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_HOLD;
      hold_cnt_q   <= '0;
      exe_sh       <= '0;
      mem_sh       <= '0;
      wb_sh        <= '0;
      fwd_src1_sel <= FWD_REGFILE;
      fwd_src2_sel <= FWD_REGFILE;
    end else begin
      state_q <= state_d;

      if (state_q == ST_HOLD && !hold_done)
        hold_cnt_q <= hold_cnt_q + CNT_W'(1);
      else
        hold_cnt_q <= '0;

      // EXE shadow and forwarding selects travel with the DEC/EXE register.
      if (dec_kill) begin
        exe_sh       <= '0;
        fwd_src1_sel <= FWD_REGFILE;
        fwd_src2_sel <= FWD_REGFILE;
      end else if (dec_advance) begin
        exe_sh.valid <= 1'b1;
        exe_sh.we    <= dec_we & ~dec_nop_gen;
        exe_sh.rd    <= dec_rd;
        exe_sh.cmd   <= dec_hazard_cmd;
        fwd_src1_sel <= fwd1_d;
        fwd_src2_sel <= fwd2_d;
      end

      if (exe_enb)
        mem_sh <= exe_sh;

      // A frozen MEM stage hands WB a bubble rather than a repeat.
      if (mem_enb)
        wb_sh <= mem_sh;
      else
        wb_sh <= '0;
    end
  end

  // The WB shadow completes the per-stage record for debug visibility. The
  // current hazard rules never consult it, because the regfile itself
  // covers WB-to-DEC.
  logic unused_wb_sh;
  assign unused_wb_sh = ^wb_sh;

  // CMD_OTHER names the remaining encoding for readers. It only ever
  // appears as the fall-through case.
  logic [1:0] unused_cmd_other;
  assign unused_cmd_other = CMD_OTHER;

endmodule

// File: tb/tb_core_hzrd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_core_hzrd_ctrl
//
// Directed bench for core_hzrd_ctrl with RST_HOLD_CYCLES = 2.
// Inputs change just after the falling edge. Outputs are sampled 1 ns later,
// well before the next rising edge. Expected values are hand-derived
// constants.
// -----------------------------------------------------------------------------
module tb_core_hzrd_ctrl;

  logic        clk;
  logic        rst;
  logic [14:0] dec_hazard_bus;
  logic [1:0]  dec_hazard_cmd;
  logic        dec_we;
  logic        il1_ack;
  logic        dl1_req;
  logic        dl1_ack;
  logic        exe_brnch_taken;
  logic        if_enb;
  logic        dec_enb;
  logic        exe_enb;
  logic        mem_enb;
  logic        dec_kill;
  logic        dec_nop_gen;
  logic [1:0]  pc_sel;
  logic [1:0]  fwd_src1_sel;
  logic [1:0]  fwd_src2_sel;
  logic        stall_out;

  int checks;
  int errors;

  core_hzrd_ctrl #(.RST_HOLD_CYCLES(2)) dut (
    .clk             (clk),
    .rst             (rst),
    .dec_hazard_bus  (dec_hazard_bus),
    .dec_hazard_cmd  (dec_hazard_cmd),
    .dec_we          (dec_we),
    .il1_ack         (il1_ack),
    .dl1_req         (dl1_req),
    .dl1_ack         (dl1_ack),
    .exe_brnch_taken (exe_brnch_taken),
    .if_enb          (if_enb),
    .dec_enb         (dec_enb),
    .exe_enb         (exe_enb),
    .mem_enb         (mem_enb),
    .dec_kill        (dec_kill),
    .dec_nop_gen     (dec_nop_gen),
    .pc_sel          (pc_sel),
    .fwd_src1_sel    (fwd_src1_sel),
    .fwd_src2_sel    (fwd_src2_sel),
    .stall_out       (stall_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Control vector: {if,dec,exe,mem, kill, nop, pc_sel[1:0], stall}
  localparam logic [8:0] C_HOLD   = 9'b0000_1_1_00_1;
  localparam logic [8:0] C_RUN    = 9'b1111_0_0_00_0;
  localparam logic [8:0] C_FREEZE = 9'b0000_0_0_00_1;
  localparam logic [8:0] C_REDIR  = 9'b1111_1_0_01_0;
  localparam logic [8:0] C_LDUSE  = 9'b0111_1_0_00_1;
  localparam logic [8:0] C_IMISS  = 9'b0111_0_1_00_1;
  localparam logic [8:0] C_FLUSH  = 9'b1111_0_1_00_0;

  logic [8:0] ctl;
  logic [3:0] fwd;
  assign ctl = {if_enb, dec_enb, exe_enb, mem_enb, dec_kill, dec_nop_gen, pc_sel, stall_out};
  assign fwd = {fwd_src1_sel, fwd_src2_sel};

  task automatic check(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        errors++;
        $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  task automatic set_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                         input logic [1:0] cmd, input logic we);
    dec_hazard_bus = {rs1, rs2, rd};
    dec_hazard_cmd = cmd;
    dec_we         = we;
  endtask

  // Advance to the next falling edge; caller then drives and checks.
  task automatic next_cycle();
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    il1_ack = 1'b1;
    dl1_req = 1'b0;
    dl1_ack = 1'b0;
    exe_brnch_taken = 1'b0;
    set_dec(5'd0, 5'd0, 5'd0, 2'b00, 1'b0);

    // Reset held for three rising edges.
    next_cycle(); #1;
    check("reset_ctl", 16'(ctl), 16'(C_HOLD));
    check("reset_fwd", 16'(fwd), 16'h0);
    next_cycle();
    next_cycle();
    rst = 1'b0;
    #1 check("hold_cycle0", 16'(ctl), 16'(C_HOLD));
    next_cycle(); #1;
    check("hold_cycle1", 16'(ctl), 16'(C_HOLD));

    // R1: first enabled cycle; add r3 <- r1,r2
    next_cycle();
    set_dec(5'd1, 5'd2, 5'd3, 2'b00, 1'b1);
    #1 check("run_after_hold", 16'(ctl), 16'(C_RUN));

    // R2: consumer of r3 right behind the add; no stall
    next_cycle();
    set_dec(5'd3, 5'd4, 5'd6, 2'b00, 1'b1);
    #1 check("alu_b2b_no_stall", 16'(ctl), 16'(C_RUN));

    // R3: r3 now in MEM, r6 in EXE; producer rd=0
    next_cycle();
    set_dec(5'd3, 5'd6, 5'd0, 2'b00, 1'b1);
    #1 check("fwd_exe_rs1", 16'(fwd), 16'b01_00);

    // R4: rs1=0 against rd=0 producer; rs2=6 now in MEM
    next_cycle();
    set_dec(5'd0, 5'd6, 5'd6, 2'b00, 1'b1);
    #1 check("fwd_mem_and_exe", 16'(fwd), 16'b10_01);

    // R5
    next_cycle();
    set_dec(5'd6, 5'd7, 5'd6, 2'b00, 1'b1);
    #1 check("fwd_rd0_none", 16'(fwd), 16'b00_10);

    // R6: r6 in both EXE and MEM, EXE wins; DEC holds a load r5
    next_cycle();
    set_dec(5'd6, 5'd6, 5'd5, 2'b11, 1'b1);
    #1 check("fwd_exe_only", 16'(fwd), 16'b01_00);

    // R7: load r5 in EXE, DEC reads rs2=5 -> one bubble
    next_cycle();
    set_dec(5'd1, 5'd5, 5'd7, 2'b00, 1'b1);
    #1 check("fwd_exe_priority", 16'(fwd), 16'b01_01);
    check("load_use_stall", 16'(ctl), 16'(C_LDUSE));

    // R8: same DEC word, bubble in EXE -> released
    next_cycle();
    #1 check("load_use_single_bubble", 16'(ctl), 16'(C_RUN));
    check("fwd_cleared_on_kill", 16'(fwd), 16'h0);

    // R9: DEC load r9
    next_cycle();
    set_dec(5'd0, 5'd0, 5'd9, 2'b11, 1'b1);
    #1 check("fwd_load_from_wb", 16'(fwd), 16'b00_10);
    check("load_no_hazard", 16'(ctl), 16'(C_RUN));

    // R10: load-use together with I-cache miss
    next_cycle();
    set_dec(5'd9, 5'd0, 5'd2, 2'b00, 1'b1);
    il1_ack = 1'b0;
    #1 check("load_use_over_imiss", 16'(ctl), 16'(C_LDUSE));

    // R11: I-cache miss alone
    next_cycle();
    #1 check("imiss", 16'(ctl), 16'(C_IMISS));

    // R12: branch in DEC; NOP'd r2 producer must not forward
    next_cycle();
    il1_ack = 1'b1;
    set_dec(5'd2, 5'd0, 5'd0, 2'b01, 1'b0);
    #1 check("fwd_rs1_mem_load", 16'(fwd), 16'b10_00);
    check("run_after_imiss", 16'(ctl), 16'(C_RUN));

    // R13: branch taken in EXE
    next_cycle();
    set_dec(5'd1, 5'd0, 5'd4, 2'b00, 1'b1);
    exe_brnch_taken = 1'b1;
    #1 check("fwd_nop_producer", 16'(fwd), 16'h0);
    check("redirect", 16'(ctl), 16'(C_REDIR));

    // R14: FLUSH; stray taken is ignored
    next_cycle();
    #1 check("flush", 16'(ctl), 16'(C_FLUSH));

    // R15: back to RUN; jump r1 enters DEC
    next_cycle();
    exe_brnch_taken = 1'b0;
    set_dec(5'd0, 5'd0, 5'd1, 2'b10, 1'b1);
    #1 check("run_after_flush", 16'(ctl), 16'(C_RUN));

    // R16..R19: D-cache wait with a concurrent redirect pending
    next_cycle();
    set_dec(5'd1, 5'd0, 5'd8, 2'b00, 1'b1);
    dl1_req = 1'b1;
    dl1_ack = 1'b0;
    exe_brnch_taken = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1 check($sformatf("dwait_freeze%0d", i), 16'(ctl), 16'(C_FREEZE));
      next_cycle();
    end

    // R20: ack releases and the held redirect applies
    dl1_ack = 1'b1;
    #1 check("dwait_release_redirect", 16'(ctl), 16'(C_REDIR));

    // R21
    next_cycle();
    dl1_req = 1'b0;
    dl1_ack = 1'b0;
    exe_brnch_taken = 1'b0;
    #1 check("flush_after_dwait", 16'(ctl), 16'(C_FLUSH));

    // R22: add r3
    next_cycle();
    set_dec(5'd0, 5'd0, 5'd3, 2'b00, 1'b1);
    #1 check("run_after_dwait_flush", 16'(ctl), 16'(C_RUN));

    // R23: consumer of r3
    next_cycle();
    set_dec(5'd3, 5'd0, 5'd4, 2'b00, 1'b1);
    #1 check("run_pre_reset", 16'(ctl), 16'(C_RUN));

    // R24: D-cache wait plus I-cache miss -> DWAIT wins
    next_cycle();
    dl1_req = 1'b1;
    il1_ack = 1'b0;
    #1 check("fwd_pre_reset", 16'(fwd), 16'b01_00);
    check("dwait_over_imiss", 16'(ctl), 16'(C_FREEZE));

    // R25: rst pulse while in DWAIT
    next_cycle();
    rst = 1'b1;
    #1 check("dwait_before_rst_edge", 16'(ctl), 16'(C_FREEZE));

    // R26, R27: back in HOLD
    next_cycle();
    rst = 1'b0;
    dl1_req = 1'b0;
    il1_ack = 1'b1;
    set_dec(5'd3, 5'd4, 5'd5, 2'b00, 1'b1);
    #1 check("midop_reset_hold", 16'(ctl), 16'(C_HOLD));
    check("midop_reset_fwd", 16'(fwd), 16'h0);
    next_cycle(); #1;
    check("midop_hold_cycle1", 16'(ctl), 16'(C_HOLD));

    // R28: RUN, DEC reads r3/r4 whose producers were wiped
    next_cycle(); #1;
    check("midop_run", 16'(ctl), 16'(C_RUN));

    // R29: without cleared shadows the stale r3 in MEM would select 10
    next_cycle(); #1;
    check("midop_shadows_cleared", 16'(fwd), 16'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/core_hzrd_ctrl.md
# core_hzrd_ctrl

Pipeline sequencer and hazard controller for the five-stage Selen core (IF, DEC, EXE, MEM, WB). Drives the stage enables and kills of the IF/DEC, DEC/EXE and EXE/MEM registers. Generates NOP injection into decode, the PC-redirect select and the EXE-stage operand-forwarding selects. Keeps its own shadow pipeline of destination registers and instruction types for EXE, MEM and WB, fed from the decode hazard bus.

## Interface
- RST_HOLD_CYCLES, 2, cycles after reset release during which every stage is held killed (≥1)
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- dec_hazard_bus  in  15  {rs1[14:10], rs2[9:5], rd[4:0]} of the instruction in DEC
- dec_hazard_cmd  in  2  type of the DEC instruction: 00 other, 01 branch, 10 jump, 11 load
- dec_we  in  1  DEC instruction writes the register file
- il1_ack  in  1  instruction cache returned a valid word this cycle
- dl1_req  in  1  MEM stage holds a valid load/store request
- dl1_ack  in  1  data cache completed the MEM request
- exe_brnch_taken  in  1  EXE resolved a taken branch or jump
- if_enb, dec_enb, exe_enb, mem_enb  out  1 each  stage register load enables
- dec_kill  out  1  load a bubble into the DEC/EXE register
- dec_nop_gen  out  1  decode treats its instruction as NOP
- pc_sel  out  2  00 PC+4, 01 EXE branch/jump target, others reserved (never driven)
- fwd_src1_sel, fwd_src2_sel  out  2 each  registered, EXE-stage operand source: 00 regfile, 01 MEM-stage ALU result, 10 WB data
- stall_out  out  1  any stall or hold active (status)

## Operation
- Shadow entries: {valid, we, rd[4:0], cmd[1:0]} for EXE, MEM and WB.
- Shadow update:
  - DEC advance (dec_enb & !dec_kill): exe_sh <= {1, dec_we & !dec_nop_gen, rd, cmd}.
  - dec_kill: exe_sh <= 0.
  - exe_enb: mem_sh <= exe_sh.
  - mem_enb: wb_sh <= mem_sh; otherwise wb_sh <= 0.
- FSM states:
  - HOLD: reset, counting RST_HOLD_CYCLES.
  - RUN: normal operation.
  - FLUSH: one cycle after a redirect.
  - DWAIT: data-cache wait.
- Transitions:
  - HOLD→RUN when the counter reaches RST_HOLD_CYCLES-1.
  - RUN→DWAIT on dl1_req & !dl1_ack; DWAIT→RUN on dl1_ack.
  - RUN→FLUSH on taken redirect; FLUSH→RUN unconditionally, or FLUSH→DWAIT if the DWAIT condition holds.
- Priority within RUN, highest first:
  1. **DWAIT condition** (dl1_req & !dl1_ack): all four enables 0 and dec_kill 0, so every stage freezes. WB receives a bubble.
  2. **Redirect** (exe_brnch_taken & exe_sh.valid & exe_sh.cmd ∈ {01,10}): pc_sel=01, dec_kill=1, all enables 1, next state FLUSH.
  3. **Load-use**: exe_sh.valid & exe_sh.cmd=11 & exe_sh.we & exe_sh.rd≠0 & (exe_sh.rd==rs1 | exe_sh.rd==rs2). Outputs: if_enb=0, dec_enb=1, dec_kill=1, exe_enb=mem_enb=1. Exactly one bubble per match.
  4. **I-cache miss** (!il1_ack): if_enb=0, dec_nop_gen=1. DEC, EXE and MEM enables stay 1.
  5. **Otherwise**: all enables 1, kills 0, pc_sel=00.
- FLUSH: dec_nop_gen=1 (the wrong-path word in IF/DEC is squashed), all enables 1, pc_sel=00.
- HOLD: all enables 0, dec_kill=1, dec_nop_gen=1, stall_out=1.
- Forwarding selects are computed per source on DEC advance and registered with the DEC/EXE register:
  - 01 if exe_sh.valid & exe_sh.we & exe_sh.rd≠0 & match.
  - else 10 if the same condition holds for mem_sh.
  - else 00.
  - The EXE match takes priority over the MEM match.
  - On dec_kill the selects are cleared to 00.
  - A load in exe_sh never yields 01: the load-use stall covers it.
- stall_out = 1 in HOLD, DWAIT, load-use or I-cache miss.

## Timing
- Reset values: state HOLD, counter 0, all shadows 0, fwd selects 00. Combinational outputs in HOLD: enables 0, dec_kill 1, dec_nop_gen 1, pc_sel 00, stall_out 1.
- All outputs except the fwd selects are combinational from state, shadows and current inputs. Redirect reaches pc_sel in the same cycle as exe_brnch_taken.
- First enabled cycle is cycle RST_HOLD_CYCLES after rst deasserts.
- rst asserted mid-operation (including in DWAIT or FLUSH): returns to HOLD on the next edge, and shadows are cleared.
- Redirect while FSM in FLUSH cannot occur, because exe_sh holds a bubble. If it is asserted anyway it is ignored.
- Simultaneous cases:
  - Load-use and I-cache miss: load-use outputs take effect and dec_nop_gen=0.
  - Redirect and load-use: redirect wins.
  - dl1 wait and anything else: DWAIT wins and the other event is re-evaluated after dl1_ack.

## Test plan
- **Reset**: rst high 3 cycles then low with RST_HOLD_CYCLES=2 -> enables 0 and dec_kill 1 for 2 cycles, then all enables 1, stall_out 0.
- **Load-use**: load with rd=5 in EXE, DEC rs2=5 -> one cycle if_enb=0, dec_kill=1. Next DEC advance registers fwd_src2_sel=10.
- **ALU back-to-back**: add rd=3 then use rs1=3 -> fwd_src1_sel=01, no stall. rd=0 producer -> fwd_src1_sel=00.
- **Taken branch**: exe_brnch_taken=1 with branch in EXE -> same cycle pc_sel=01, dec_kill=1; next cycle dec_nop_gen=1; then RUN.
- **D-cache wait**: dl1_req=1, dl1_ack low 4 cycles -> enables 0 for 4 cycles; releases the cycle dl1_ack=1. A concurrent redirect is applied after release.
- **Mid-operation reset**: il1_ack low plus rst pulse during DWAIT -> HOLD, shadows cleared, fwd selects 00.
